// File: rtl/store_buffer_unit_pkg.sv
// Shared constants and types for the store buffer: default geometry and drain FSM encoding.
package store_buffer_unit_pkg;
  localparam int DEF_SB_ADDR_SIZE = 2;
  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 32;

  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_WRITE = 1'b1
  } sb_state_e;
endpackage

// File: rtl/store_buffer_unit_fwd_select.sv
// Store-to-load forwarding: youngest valid entry whose address equals the load address wins.
module store_fwd_select
  import store_buffer_unit_pkg::*;
#(
  parameter int SB_ADDR_SIZE = DEF_SB_ADDR_SIZE,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  logic [SB_ADDR_SIZE:0]                                  head,
  input  logic [SB_ADDR_SIZE:0]                                  tail,
  input  logic [(1 << SB_ADDR_SIZE)-1:0][ADDR_WIDTH-1:0]         ent_addr,
  input  logic [(1 << SB_ADDR_SIZE)-1:0][DATA_WIDTH-1:0]         ent_data,
  input  logic [ADDR_WIDTH-1:0]                                  ld_addr,
  output logic                                                   ld_hit,
  output logic [DATA_WIDTH-1:0]                                  ld_data
);
  localparam int DEPTH = 1 << SB_ADDR_SIZE;
  localparam int PW    = SB_ADDR_SIZE + 1;

  logic [PW-1:0]    count_s;
  logic [DEPTH-1:0] match_s;
  logic [DATA_WIDTH-1:0] data_s;

  assign count_s = tail - head;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    match_s = {DEPTH{1'b0}};
    data_s  = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = (PW'(i) < count_s) &&
                   (ent_addr[head[SB_ADDR_SIZE-1:0] + SB_ADDR_SIZE'(i)] == ld_addr);
      data_s     = match_s[i] ? ent_data[head[SB_ADDR_SIZE-1:0] + SB_ADDR_SIZE'(i)] : data_s;
    end
  end

  assign ld_hit  = |match_s;
  assign ld_data = data_s;
endmodule

// File: rtl/store_buffer_unit.sv
// EX-stage store buffer: speculative enqueue, WB-driven commit, flush of uncommitted
// entries, in-order drain to data memory and store-to-load forwarding.
module store_buffer_unit
  import store_buffer_unit_pkg::*;
#(
  parameter int SB_ADDR_SIZE = DEF_SB_ADDR_SIZE,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  commit_st,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_hit,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  sb_full,
  output logic                  sb_empty,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_ack,
  output logic                  overflow_err,
  output logic                  commit_err
);
  localparam int DEPTH = 1 << SB_ADDR_SIZE;
  localparam int PW    = SB_ADDR_SIZE + 1;

  logic [PW-1:0] head_r, cmt_r, tail_r;
  logic [PW-1:0] used_s, cmt_next_s, head_next_s;
  logic          full_s, enq_s, cmt_ok_s;
  sb_state_e     state_r;

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr_r;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data_r;

  assign used_s      = tail_r - head_r;
  assign full_s      = (used_s == PW'(DEPTH));
  assign sb_full     = full_s;
  assign sb_empty    = (tail_r == head_r);
  assign enq_s       = st_valid && !full_s && !flush;
  // A store accepted in the same cycle is committable even when cmt has caught up with tail.
  assign cmt_ok_s    = commit_st && ((cmt_r != tail_r) || enq_s);
  assign cmt_next_s  = cmt_r + {{SB_ADDR_SIZE{1'b0}}, cmt_ok_s};
  assign head_next_s = head_r + {{SB_ADDR_SIZE{1'b0}}, 1'b1};

  // Commit/tail pointers and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmt_r        <= {PW{1'b0}};
      tail_r       <= {PW{1'b0}};
      overflow_err <= 1'b0;
      commit_err   <= 1'b0;
    end else begin
      cmt_r <= cmt_next_s;
      if (flush) begin
        tail_r <= cmt_next_s;
      end else if (enq_s) begin
        tail_r <= tail_r + {{SB_ADDR_SIZE{1'b0}}, 1'b1};
      end
      if (st_valid && full_s) begin
        overflow_err <= 1'b1;
      end
      if (commit_st && !cmt_ok_s) begin
        commit_err <= 1'b1;
      end
    end
  end

  // Entry storage, written at the tail slot on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_addr_r <= {(DEPTH*ADDR_WIDTH){1'b0}};
      ent_data_r <= {(DEPTH*DATA_WIDTH){1'b0}};
    end else if (enq_s) begin
      ent_addr_r[tail_r[SB_ADDR_SIZE-1:0]] <= st_addr;
      ent_data_r[tail_r[SB_ADDR_SIZE-1:0]] <= st_data;
    end
  end

  // Drain FSM: presents committed entries at head until acknowledged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= SB_IDLE;
      head_r      <= {PW{1'b0}};
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= {ADDR_WIDTH{1'b0}};
      mem_wr_data <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        SB_IDLE: begin
          if (head_r != cmt_r) begin
            state_r     <= SB_WRITE;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= ent_addr_r[head_r[SB_ADDR_SIZE-1:0]];
            mem_wr_data <= ent_data_r[head_r[SB_ADDR_SIZE-1:0]];
          end
        end
        SB_WRITE: begin
          if (mem_wr_ack) begin
            head_r <= head_next_s;
            // Compare against the registered cmt: the next entry must already be in storage.
            if (head_next_s != cmt_r) begin
              mem_wr_addr <= ent_addr_r[head_next_s[SB_ADDR_SIZE-1:0]];
              mem_wr_data <= ent_data_r[head_next_s[SB_ADDR_SIZE-1:0]];
            end else begin
              state_r   <= SB_IDLE;
              mem_wr_en <= 1'b0;
            end
          end
        end
        default: begin
          state_r   <= SB_IDLE;
          mem_wr_en <= 1'b0;
        end
      endcase
    end
  end

  store_fwd_select #(
    .SB_ADDR_SIZE (SB_ADDR_SIZE),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_fwd (
    .head     (head_r),
    .tail     (tail_r),
    .ent_addr (ent_addr_r),
    .ent_data (ent_data_r),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data)
  );
endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed self-checking bench for store_buffer_unit with a write-port monitor.
module tb_store_buffer_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, commit_st, flush, mem_wr_ack;
  logic [31:0] st_addr, st_data, ld_addr;
  logic        ld_hit, sb_full, sb_empty, mem_wr_en, overflow_err, commit_err;
  logic [31:0] ld_data, mem_wr_addr, mem_wr_data;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  store_buffer_unit dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .commit_st(commit_st), .flush(flush), .ld_addr(ld_addr), .ld_hit(ld_hit),
    .ld_data(ld_data), .sb_full(sb_full), .sb_empty(sb_empty), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
    .overflow_err(overflow_err), .commit_err(commit_err)
  );

  always #5 clk = ~clk;

  // Record every accepted write.
  always @(posedge clk) begin
    if (reset && mem_wr_en && mem_wr_ack) begin
      wq_addr.push_back(mem_wr_addr);
      wq_data.push_back(mem_wr_data);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic cm);
    st_valid = 1'b1; st_addr = a; st_data = d; commit_st = cm;
    step(1);
    st_valid = 1'b0; commit_st = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [31:0] ea[$], input logic [31:0] ed[$]);
    check_val({tag, "_count"}, 32'(wq_addr.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < wq_addr.size(); i++) begin
      check_val($sformatf("%s_addr%0d", tag, i), wq_addr[i], ea[i]);
      check_val($sformatf("%s_data%0d", tag, i), wq_data[i], ed[i]);
    end
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    reset = 1'b0; st_valid = 1'b0; commit_st = 1'b0; flush = 1'b0; mem_wr_ack = 1'b0;
    st_addr = 32'h0; st_data = 32'h0; ld_addr = 32'h0;
    step(2);
    check_val("rst_wr_en", {31'h0, mem_wr_en}, 32'h0);
    check_val("rst_wr_addr", mem_wr_addr, 32'h0);
    check_val("rst_wr_data", mem_wr_data, 32'h0);
    check_val("rst_full", {31'h0, sb_full}, 32'h0);
    check_val("rst_empty", {31'h0, sb_empty}, 32'h1);
    check_val("rst_hit", {31'h0, ld_hit}, 32'h0);
    check_val("rst_ld_data", ld_data, 32'h0);
    check_val("rst_ovf", {31'h0, overflow_err}, 32'h0);
    check_val("rst_cerr", {31'h0, commit_err}, 32'h0);
    reset = 1'b1;
    step(1);

    // Basic store, commit, drain
    mem_wr_ack = 1'b1;
    put(32'h100, 32'h11, 1'b0);
    commit_st = 1'b1;
    step(1);
    commit_st = 1'b0;
    check_val("basic_en_early", {31'h0, mem_wr_en}, 32'h0);
    step(1);
    check_val("basic_en", {31'h0, mem_wr_en}, 32'h1);
    check_val("basic_addr", mem_wr_addr, 32'h100);
    check_val("basic_data", mem_wr_data, 32'h11);
    step(1);
    check_val("basic_en_done", {31'h0, mem_wr_en}, 32'h0);
    check_val("basic_empty", {31'h0, sb_empty}, 32'h1);
    ea = '{32'h100}; ed = '{32'h11};
    check_writes("basic", ea, ed);

    // Fill, overflow, drain, wrap
    for (int i = 0; i < 4; i++) put(32'h300 + 32'(4 * i), 32'h30 + 32'(i), 1'b0);
    check_val("full", {31'h0, sb_full}, 32'h1);
    check_val("ovf_before", {31'h0, overflow_err}, 32'h0);
    put(32'h3F0, 32'h3F, 1'b0);
    check_val("ovf", {31'h0, overflow_err}, 32'h1);
    check_val("full_still", {31'h0, sb_full}, 32'h1);
    commit_st = 1'b1;
    step(4);
    commit_st = 1'b0;
    step(8);
    check_val("drain_empty", {31'h0, sb_empty}, 32'h1);
    for (int i = 0; i < 4; i++) put(32'h400 + 32'(4 * i), 32'h40 + 32'(i), 1'b0);
    check_val("wrap_full", {31'h0, sb_full}, 32'h1);
    commit_st = 1'b1;
    step(4);
    commit_st = 1'b0;
    step(8);
    check_val("wrap_empty", {31'h0, sb_empty}, 32'h1);
    check_val("wrap_cerr", {31'h0, commit_err}, 32'h0);
    ea = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h400, 32'h404, 32'h408, 32'h40C};
    ed = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h40, 32'h41, 32'h42, 32'h43};
    check_writes("wrap", ea, ed);

    // Forwarding from uncommitted entries
    ld_addr = 32'h200;
    put(32'h200, 32'hAA, 1'b0);
    check_val("fwd1_hit", {31'h0, ld_hit}, 32'h1);
    check_val("fwd1_data", ld_data, 32'hAA);
    put(32'h200, 32'hBB, 1'b0);
    check_val("fwd2_hit", {31'h0, ld_hit}, 32'h1);
    check_val("fwd2_data", ld_data, 32'hBB);
    ld_addr = 32'h204;
    #1;
    check_val("fwd_miss_hit", {31'h0, ld_hit}, 32'h0);
    check_val("fwd_miss_data", ld_data, 32'h0);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    ld_addr = 32'h200;
    #1;
    check_val("fwd_flushed_hit", {31'h0, ld_hit}, 32'h0);
    check_val("fwd_flushed_empty", {31'h0, sb_empty}, 32'h1);

    // Flush keeps committed, drops uncommitted
    put(32'h500, 32'h51, 1'b0);
    put(32'h504, 32'h52, 1'b0);
    put(32'h508, 32'h53, 1'b0);
    commit_st = 1'b1;
    step(1);
    commit_st = 1'b0;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(5);
    check_val("flush_empty", {31'h0, sb_empty}, 32'h1);
    ld_addr = 32'h504;
    #1;
    check_val("flush_fwd_miss", {31'h0, ld_hit}, 32'h0);
    ea = '{32'h500}; ed = '{32'h51};
    check_writes("flush", ea, ed);

    // Same-cycle store and commit on empty buffer
    put(32'h600, 32'h61, 1'b1);
    step(4);
    ea = '{32'h600}; ed = '{32'h61};
    check_writes("same", ea, ed);
    check_val("cerr_before", {31'h0, commit_err}, 32'h0);
    commit_st = 1'b1;
    step(1);
    commit_st = 1'b0;
    check_val("cerr", {31'h0, commit_err}, 32'h1);

    // Withheld ack: request held stable
    mem_wr_ack = 1'b0;
    put(32'h700, 32'h71, 1'b1);
    step(1);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("stall_en%0d", i), {31'h0, mem_wr_en}, 32'h1);
      check_val($sformatf("stall_addr%0d", i), mem_wr_addr, 32'h700);
      check_val($sformatf("stall_data%0d", i), mem_wr_data, 32'h71);
      step(1);
    end
    mem_wr_ack = 1'b1;
    step(1);
    check_val("stall_done_en", {31'h0, mem_wr_en}, 32'h0);
    ea = '{32'h700}; ed = '{32'h71};
    check_writes("stall", ea, ed);

    // Asynchronous reset during a pending write
    mem_wr_ack = 1'b0;
    put(32'h800, 32'h81, 1'b1);
    step(1);
    check_val("ar_en_before", {31'h0, mem_wr_en}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check_val("ar_en", {31'h0, mem_wr_en}, 32'h0);
    check_val("ar_empty", {31'h0, sb_empty}, 32'h1);
    check_val("ar_cerr", {31'h0, commit_err}, 32'h0);
    step(2);
    reset = 1'b1;
    mem_wr_ack = 1'b1;
    step(5);
    check_val("ar_no_en", {31'h0, mem_wr_en}, 32'h0);
    ea.delete(); ed.delete();
    check_writes("ar", ea, ed);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
